tile_render_ctrl: RTL and testbench
===================================

TILE_RENDER_CTRL -- requirements
Module: tile_render_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FIFO_DEPTH, 4: command queue entries, power of two.
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- KEY_COLOR, 16'hF81F: transparent RGB565 value.
- KEY_EN, 1: enables transparency skip.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- rstn, in, 1: synchronous active-low reset.
- cmd_valid, in, 1: draw command offered.
- cmd_ready, out, 1: queue can accept a command.
- cmd_tile, in, 9: tile index in the tile ROM.
- cmd_top, in, 10: tile origin y.
- cmd_left, in, 10: tile origin x.
- flush, in, 1: abort the current tile and empty the queue.
- rom_addr, out, 19: tile ROM pixel address.
- rom_data, in, 16: ROM color, valid within 2 cycles of rom_addr.
- px_x, out, 10: destination pixel x.
- px_y, out, 10: destination pixel y.
- px_color, out, 16: pixel color.
- px_wr, out, 1: one-cycle pixel write strobe.
- busy, out, 1: high when the FSM is not in IDLE or the queue is non-empty.
- tile_done, out, 1: one-cycle pulse per completed tile.

Function
REQ-003 The block SHALL accept a command on a cycle where cmd_valid and cmd_ready are both high, and SHALL write it into a FIFO_DEPTH-entry queue.
REQ-004 cmd_ready SHALL equal "queue not full" and SHALL be registered; there is no pass-through while full. An offer made while full SHALL be ignored.
REQ-005 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
- IDLE goes to LOAD when the queue is non-empty.
- LOAD latches the head entry, pops it, clears the 12-bit counter cnt, and goes to RUN.
- RUN increments cnt every cycle and goes to DONE when cnt==4095.
- DONE pulses tile_done and goes to IDLE.
REQ-006 Latency: a command accepted at cycle T with the queue empty and the FSM in IDLE SHALL give LOAD at T+2, RUN with cnt=0 at T+3, and the first px_wr at T+6.
REQ-007 Each tile SHALL cost 4099 cycles from LOAD to the return to IDLE.
REQ-008 In RUN, rom_addr SHALL be {cmd_tile,10'b0} + cnt[11:2], held for all 4 cycles of a pixel. Outside RUN, rom_addr SHALL be 0.
REQ-009 In RUN, px_x SHALL be left + cnt[6:2] and px_y SHALL be top + cnt[11:7], both truncated to 10 bits (mod-1024 wrap). px_color SHALL be rom_data.
REQ-010 px_wr SHALL be asserted only in RUN with cnt[1:0]==3, and only if all of the following hold:
- px_x < H_RES;
- px_y < V_RES;
- KEY_EN==0 or px_color != KEY_COLOR.
REQ-011 Each tile SHALL produce at most 1024 px_wr pulses, in raster order: x fastest, then y.
REQ-012 A flush sampled high SHALL make the next state IDLE and empty the queue, suppress px_wr from the following cycle on, and produce no tile_done for the aborted tile.
REQ-013 If flush and an accepted command coincide, flush SHALL win and the command SHALL be discarded.
REQ-014 A push and a pop in the same cycle SHALL leave the occupancy unchanged and lose no entry. Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-015 While rstn is low at a clock edge, the block SHALL reset to:
- FSM in IDLE;
- queue empty, pointers 0;
- cnt = 0;
- cmd_ready = 1;
- px_wr = 0, tile_done = 0, busy = 0;
- rom_addr, px_x, px_y, px_color = 0.
REQ-016 A reset during RUN SHALL abort the tile with no further px_wr and no tile_done.

Structure
REQ-017 TILE_PIX_LOG (10), TILE_SIZE_LOG (5), the RGB565 color width and the default KEY_COLOR SHALL live in the shared render package.
REQ-018 The command queue SHALL be a sub-module named cmd_fifo, parameterized by width (29) and depth. The FSM, counter and pixel/clip logic SHALL stay in tile_render_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- tile=3, top=0, left=0, ROM all 16'h07E0: rom_addr starts at 3072; 1024 px_wr pulses; first at T+6 with px=(0,0); last px=(31,31); a single tile_done.
- left=620, top=470, ROM non-key: only x 620..639 and y 470..479 are written, giving 200 px_wr pulses.
- ROM pixels with an even index equal F81F, KEY_EN=1: 512 px_wr pulses. With KEY_EN=0: 1024.
- Push 5 commands back-to-back, each with cmd_valid held until accepted: cmd_ready drops after 4 are queued. The 5th is accepted after the first LOAD. 5 tile_done pulses, spaced 4099 cycles apart.
- Flush at cnt=1000 with 2 commands queued: px_wr stays 0; busy drops within 2 cycles; no tile_done.
- Reset at cnt=2000: all outputs at reset values; the next command behaves as in the first scenario.

Source files
------------

// File: rtl/tile_render_pkg.sv
// Shared render constants, command layout and FSM state type for the tile renderer.
package tile_render_pkg;

    localparam int unsigned TILE_PIX_LOG  = 10;
    localparam int unsigned TILE_SIZE_LOG = 5;
    localparam int unsigned COLOR_W       = 16;
    localparam int unsigned CNT_W         = TILE_PIX_LOG + 2;
    localparam int unsigned CMD_W         = 29;

    localparam logic [COLOR_W-1:0] DEFAULT_KEY_COLOR = 16'hF81F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [8:0] tile;
        logic [9:0] top;
        logic [9:0] left;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Draw-command queue with a registered "not full" ready and a synchronous clear.
module cmd_fifo #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    // Next queue contents, pointers, occupancy; ready looks at the next occupancy so it is a flop.
    always_comb begin
        do_push  = push && ready_q;
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != FULL_CNT);
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign ready = ready_q;

endmodule

// File: rtl/tile_render_ctrl.sv
// Tile renderer: queues draw commands and walks each 32x32 tile, 4 cycles per pixel,
// emitting clipped and colour-keyed pixel writes in raster order.
module tile_render_ctrl
    import tile_render_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter int unsigned        H_RES      = 640,
    parameter int unsigned        V_RES      = 480,
    parameter logic [COLOR_W-1:0] KEY_COLOR  = DEFAULT_KEY_COLOR,
    parameter logic               KEY_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_tile,
    input  logic [9:0]         cmd_top,
    input  logic [9:0]         cmd_left,
    input  logic               flush,
    output logic [18:0]        rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [9:0]         px_x,
    output logic [9:0]         px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               px_wr,
    output logic               busy,
    output logic               tile_done
);

    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cmd_t               cmd_q, cmd_d;
    logic [CMD_W-1:0]   fifo_rdata;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    // A command arriving together with flush is dropped.
    assign fifo_push = cmd_valid && cmd_ready && !flush;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clr   (flush),
        .wdata ({cmd_tile, cmd_top, cmd_left}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .ready (cmd_ready)
    );

    // FSM next state, tile latch and pixel counter; flush overrides any transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        fifo_pop  = 1'b0;
        tile_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cmd_d    = cmd_t'(fifo_rdata);
                fifo_pop = 1'b1;
                cnt_d    = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_DONE;
            end
            ST_DONE: begin
                tile_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // FSM, counter and latched command registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    // Pixel address/position from the counter; write on the last cycle of each pixel if visible and not keyed.
    always_comb begin
        rom_addr = '0;
        px_x     = '0;
        px_y     = '0;
        px_color = '0;
        px_wr    = 1'b0;
        if (state_q == ST_RUN) begin
            rom_addr = {cmd_q.tile, {TILE_PIX_LOG{1'b0}}} + 19'(cnt_q[2 +: TILE_PIX_LOG]);
            px_x     = cmd_q.left + 10'(cnt_q[2 +: TILE_SIZE_LOG]);
            px_y     = cmd_q.top + 10'(cnt_q[2 + TILE_SIZE_LOG +: TILE_SIZE_LOG]);
            px_color = rom_data;
            px_wr    = (cnt_q[1:0] == 2'b11)
                    && ({1'b0, px_x} < H_LIM)
                    && ({1'b0, px_y} < V_LIM)
                    && (!KEY_EN || (rom_data != KEY_COLOR));
        end
    end

    assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tile_render_ctrl.sv
// Bench for tile_render_ctrl: a cycle-level model derived from the command timeline
// checks both a keyed and an unkeyed instance every cycle; directed scenarios add literal checks.
module tb_tile_render_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        flush = 1'b0;
    logic [8:0]  cmd_tile = '0;
    logic [9:0]  cmd_top = '0;
    logic [9:0]  cmd_left = '0;
    logic [15:0] rom_data1 = '0;
    logic [15:0] rom_data0 = '0;

    logic        cmd_ready1, cmd_ready0;
    logic [18:0] rom_addr1, rom_addr0;
    logic [9:0]  px_x1, px_x0, px_y1, px_y0;
    logic [15:0] px_color1, px_color0;
    logic        px_wr1, px_wr0, busy1, busy0, tile_done1, tile_done0;

    always #5 clk = ~clk;

    tile_render_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .H_RES      (640),
        .V_RES      (480),
        .KEY_COLOR  (16'hF81F),
        .KEY_EN     (1'b1)
    ) dut1 (
        .clk (clk), .rstn (rstn), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready1),
        .cmd_tile (cmd_tile), .cmd_top (cmd_top), .cmd_left (cmd_left), .flush (flush),
        .rom_addr (rom_addr1), .rom_data (rom_data1), .px_x (px_x1), .px_y (px_y1),
        .px_color (px_color1), .px_wr (px_wr1), .busy (busy1), .tile_done (tile_done1)
    );

    tile_render_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .H_RES      (640),
        .V_RES      (480),
        .KEY_COLOR  (16'hF81F),
        .KEY_EN     (1'b0)
    ) dut0 (
        .clk (clk), .rstn (rstn), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready0),
        .cmd_tile (cmd_tile), .cmd_top (cmd_top), .cmd_left (cmd_left), .flush (flush),
        .rom_addr (rom_addr0), .rom_data (rom_data0), .px_x (px_x0), .px_y (px_y0),
        .px_color (px_color0), .px_wr (px_wr0), .busy (busy0), .tile_done (tile_done0)
    );

    // Tile ROM: one-cycle read latency, content selected by rom_mode.
    int rom_mode = 0;

    function automatic logic [15:0] rom_fn(input logic [18:0] a);
        if (rom_mode == 1) return a[0] ? 16'h1234 : 16'hF81F;
        return 16'h07E0;
    endfunction

    always @(posedge clk) begin
        rom_data1 <= rom_fn(rom_addr1);
        rom_data0 <= rom_fn(rom_addr0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: pending commands plus the active tile and its age in cycles since LOAD.
    typedef struct {
        int tile;
        int top;
        int left;
    } mcmd_t;

    mcmd_t mq[$];
    mcmd_t mcur = '{0, 0, 0};
    bit    m_on = 1'b0;
    int    m_k = 0;
    bit    chk_en = 1'b0;

    int wr1 = 0, wr0 = 0;
    int first_wr_cyc = -1;
    int first_x = 0, first_y = 0, last_x = 0, last_y = 0;
    int done_cyc[$];

    int          m_cnt, m_p, e_addr, e_x, e_y;
    logic [15:0] e_col;
    bit          e_run, e_w1, e_w0, e_done, e_busy, e_rdy, col_care, m_acc;
    logic [58:0] a1, a0, e1, e0;

    // Compare both DUTs to the model, update event counters, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            e_run    = m_on && (m_k >= 1) && (m_k <= 4096);
            e_addr   = 0;
            e_x      = 0;
            e_y      = 0;
            e_col    = 16'h0;
            e_w1     = 1'b0;
            e_w0     = 1'b0;
            col_care = 1'b0;
            if (e_run) begin
                m_cnt    = m_k - 1;
                m_p      = m_cnt / 4;
                e_addr   = mcur.tile * 1024 + m_p;
                e_x      = (mcur.left + m_p % 32) % 1024;
                e_y      = (mcur.top + m_p / 32) % 1024;
                col_care = (m_cnt % 4) != 0;
                e_col    = rom_fn(19'(e_addr));
                if ((m_cnt % 4 == 3) && (e_x < 640) && (e_y < 480)) begin
                    e_w0 = 1'b1;
                    e_w1 = (e_col != 16'hF81F);
                end
            end
            e_done = m_on && (m_k == 4097);
            e_busy = m_on || (mq.size() != 0);
            e_rdy  = mq.size() < DEPTH;
            a1 = {rom_addr1, px_x1, px_y1, col_care ? px_color1 : 16'h0,
                  px_wr1, tile_done1, busy1, cmd_ready1};
            e1 = {19'(e_addr), 10'(e_x), 10'(e_y), col_care ? e_col : 16'h0,
                  e_w1, e_done, e_busy, e_rdy};
            a0 = {rom_addr0, px_x0, px_y0, col_care ? px_color0 : 16'h0,
                  px_wr0, tile_done0, busy0, cmd_ready0};
            e0 = {19'(e_addr), 10'(e_x), 10'(e_y), col_care ? e_col : 16'h0,
                  e_w0, e_done, e_busy, e_rdy};
            chk("model_keyed", 64'(a1), 64'(e1));
            chk("model_nokey", 64'(a0), 64'(e0));
        end

        if (px_wr1 === 1'b1) begin
            wr1++;
            if (first_wr_cyc < 0) begin
                first_wr_cyc = cyc;
                first_x      = int'(px_x1);
                first_y      = int'(px_y1);
            end
            last_x = int'(px_x1);
            last_y = int'(px_y1);
        end
        if (px_wr0 === 1'b1) wr0++;
        if (tile_done1 === 1'b1) done_cyc.push_back(cyc);

        if (!rstn) begin
            mq.delete();
            m_on = 1'b0;
            m_k  = 0;
        end else if (flush) begin
            mq.delete();
            m_on = 1'b0;
        end else begin
            m_acc = cmd_valid && (mq.size() < DEPTH);
            if (m_on) begin
                if (m_k == 0) mcur = mq.pop_front();
                if (m_k == 4097) m_on = 1'b0;
                else m_k++;
            end else if (mq.size() != 0) begin
                m_on = 1'b1;
                m_k  = 0;
            end
            if (m_acc) mq.push_back('{int'(cmd_tile), int'(cmd_top), int'(cmd_left)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_stats();
        wr1          = 0;
        wr0          = 0;
        first_wr_cyc = -1;
        done_cyc.delete();
    endtask

    // Offer a command (caller is just past a rising edge) and hold it until accepted; returns the accept cycle.
    task automatic push(input int t, input int top, input int left, output int acc_cyc);
        int   n;
        logic r;
        n         = 0;
        cmd_tile  = 9'(t);
        cmd_top   = 10'(top);
        cmd_left  = 10'(left);
        cmd_valid = 1'b1;
        acc_cyc   = -1;
        while (acc_cyc < 0) begin
            @(negedge clk);
            r = cmd_ready1;
            tick();
            if (r === 1'b1) begin
                acc_cyc = cyc - 1;
            end else if (++n > 20000) begin
                chk("push_timeout", 64'(0), 64'(1));
                acc_cyc = cyc;
            end
        end
    endtask

    task automatic chk_reset(input string s);
        chk({s, "_rom_addr"}, 64'(rom_addr1), 64'(0));
        chk({s, "_px_x"}, 64'(px_x1), 64'(0));
        chk({s, "_px_y"}, 64'(px_y1), 64'(0));
        chk({s, "_px_color"}, 64'(px_color1), 64'(0));
        chk({s, "_px_wr"}, 64'(px_wr1), 64'(0));
        chk({s, "_tile_done"}, 64'(tile_done1), 64'(0));
        chk({s, "_busy"}, 64'(busy1), 64'(0));
        chk({s, "_cmd_ready"}, 64'(cmd_ready1), 64'(1));
    endtask

    // Tile 3 at the origin, all-opaque ROM.
    task automatic run_basic(input string s);
        int t;
        clear_stats();
        rom_mode = 0;
        push(3, 0, 0, t);
        cmd_valid = 1'b0;
        wait_cyc(t + 3);
        chk({s, "_rom_addr_start"}, 64'(rom_addr1), 64'(3072));
        wait_cyc(t + 4110);
        chk({s, "_wr_count"}, 64'(wr1), 64'(1024));
        chk({s, "_first_wr_lat"}, 64'(first_wr_cyc - t), 64'(6));
        chk({s, "_first_xy"}, 64'({first_x[15:0], first_y[15:0]}), 64'(0));
        chk({s, "_last_x"}, 64'(last_x), 64'(31));
        chk({s, "_last_y"}, 64'(last_y), 64'(31));
        chk({s, "_done_count"}, 64'(done_cyc.size()), 64'(1));
        if (done_cyc.size() == 1) chk({s, "_done_cyc"}, 64'(done_cyc[0] - t), 64'(4099));
        tick();
    endtask

    initial begin : stim
        int t;
        int acc[5];
        int c;
        int w;

        rstn = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk_reset("reset");
        tick();
        rstn = 1'b1;
        tick();

        run_basic("basic");

        // Bottom-right corner: only 20x10 pixels visible.
        clear_stats();
        push(0, 470, 620, t);
        cmd_valid = 1'b0;
        wait_cyc(t + 4110);
        chk("clip_wr_keyed", 64'(wr1), 64'(200));
        chk("clip_wr_nokey", 64'(wr0), 64'(200));
        chk("clip_done", 64'(done_cyc.size()), 64'(1));
        tick();

        // Even pixels carry the key colour.
        clear_stats();
        rom_mode = 1;
        push(5, 0, 0, t);
        cmd_valid = 1'b0;
        wait_cyc(t + 4110);
        chk("key_wr_keyed", 64'(wr1), 64'(512));
        chk("key_wr_nokey", 64'(wr0), 64'(1024));
        tick();
        rom_mode = 0;

        // Five back-to-back commands into a four-entry queue.
        clear_stats();
        for (int i = 0; i < 5; i++) push(i + 1, 0, 0, acc[i]);
        cmd_valid = 1'b0;
        chk("b2b_fifth_after_load", 64'(acc[4] - acc[0]), 64'(4));
        wait_cyc(acc[0] + 5);
        chk("b2b_ready_low_full", 64'(cmd_ready1), 64'(0));
        wait_cyc(acc[0] + 20505);
        chk("b2b_done_count", 64'(done_cyc.size()), 64'(5));
        if (done_cyc.size() == 5) begin
            chk("b2b_first_done", 64'(done_cyc[0] - acc[0]), 64'(4099));
            for (int i = 1; i < 5; i++) chk("b2b_done_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'(4099));
        end
        tick();

        // Flush at cnt=1000 with two queued, coinciding with a new command offer.
        clear_stats();
        push(1, 0, 0, t);
        push(2, 0, 0, c);
        push(4, 0, 0, c);
        cmd_valid = 1'b0;
        c = t + 3 + 1000;
        wait_cyc(c - 1);
        tick();
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_tile  = 9'd7;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        w = wr1;
        wait_cyc(c + 2);
        chk("flush_busy", 64'(busy1), 64'(0));
        chk("flush_ready", 64'(cmd_ready1), 64'(1));
        wait_cyc(c + 200);
        chk("flush_no_wr", 64'(wr1 - w), 64'(0));
        chk("flush_no_done", 64'(done_cyc.size()), 64'(0));
        tick();

        // Reset while drawing at cnt=2000.
        clear_stats();
        push(2, 0, 0, t);
        cmd_valid = 1'b0;
        c = t + 3 + 2000;
        wait_cyc(c - 1);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_run_still_busy", 64'(busy1), 64'(1));
        tick();
        @(negedge clk);
        chk_reset("rst_mid");
        tick();
        rstn = 1'b1;
        w = wr1;
        wait_cyc(c + 200);
        chk("rst_no_wr", 64'(wr1 - w), 64'(0));
        chk("rst_no_done", 64'(done_cyc.size()), 64'(0));
        tick();

        run_basic("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
